// File: rtl/zbus_chain.sv
// ZX-bus IORQ/IORQGE daisy-chain manager: combinational IORQ pass-through, per-cycle owner FSM.
// Decision takes SYNC + STABLE settle cycles (or MAXWAIT); drive_ff follows rd with 1-cycle latency.
module zbus_chain #(
  parameter int NCH       = 2,
  parameter int SYNC      = 2,
  parameter int STABLE    = 2,
  parameter int MAXWAIT   = 12,
  parameter bit FREE_IORQ = 1'b0
) (
  input  logic           fclk,
  input  logic           rst_n,
  input  logic           iorq,
  input  logic           iorq_n,
  input  logic           rd,
  input  logic           porthit,
  input  logic [NCH-1:0] iorqge,
  output logic [NCH-1:0] iorq_n_out,
  output logic           drive_ff,
  output logic [3:0]     owner,
  output logic           claim_stb,
  output logic           conflict,
  output logic           forced
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DECIDE, ST_ACTIVE} state_t;

  state_t         state, state_nxt;
  logic [NCH-1:0] sync_q [SYNC];
  logic [NCH-1:0] gs, gs_prev;
  logic [3:0]     stab_cnt;
  logic [7:0]     wait_cnt;
  logic           force_pend;
  logic           cyc, gs_same, stab_hit, wait_hit;
  logic           chain_acc;
  logic           ext_any;
  logic [3:0]     ext_code, dec_owner;
  logic           dec_conflict;

  // Each device's IORQ_n is the upstream IORQ_n OR'd with every upstream IORQGE.
  always_comb begin
    chain_acc     = FREE_IORQ ? iorq_n : (!iorq || porthit);
    iorq_n_out[0] = chain_acc;
    for (int k = 1; k < NCH; k++) begin
      chain_acc     = chain_acc || iorqge[k-1];
      iorq_n_out[k] = chain_acc;
    end
  end

  assign cyc      = FREE_IORQ ? !iorq_n : iorq;
  assign gs       = sync_q[SYNC-1];
  assign gs_same  = (gs == gs_prev);
  assign stab_hit = gs_same && (stab_cnt == 4'(STABLE - 1));
  assign wait_hit = (wait_cnt == 8'(MAXWAIT - 1));

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC; s++) sync_q[s] <= '0;
      gs_prev <= '0;
    end else begin
      sync_q[0] <= iorqge;
      for (int s = 1; s < SYNC; s++) sync_q[s] <= sync_q[s-1];
      gs_prev <= gs;
    end
  end

  // Lowest-numbered claiming device wins.
  always_comb begin
    ext_any  = 1'b0;
    ext_code = 4'd0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (gs[k]) begin
        ext_any  = 1'b1;
        ext_code = 4'(k + 2);
      end
    end
  end

  always_comb begin
    dec_owner    = 4'd15;
    dec_conflict = 1'b0;
    if (FREE_IORQ) begin
      if (ext_any) begin
        dec_owner    = ext_code;
        dec_conflict = porthit;
      end else if (porthit) begin
        dec_owner = 4'd1;
      end
    end else begin
      if (porthit)      dec_owner = 4'd1;
      else if (ext_any) dec_owner = ext_code;
    end
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A cycle dropping in SETTLE always aborts, even if a decision was due.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cyc) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!cyc)                      state_nxt = ST_IDLE;
        else if (stab_hit || wait_hit) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!cyc) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      stab_cnt   <= '0;
      wait_cnt   <= '0;
      force_pend <= 1'b0;
      owner      <= 4'd0;
      conflict   <= 1'b0;
      forced     <= 1'b0;
      claim_stb  <= 1'b0;
      drive_ff   <= 1'b0;
    end else begin
      claim_stb <= 1'b0;
      drive_ff  <= (state == ST_ACTIVE) && (owner == 4'd15) && rd && cyc;
      case (state)
        ST_IDLE: begin
          stab_cnt   <= '0;
          wait_cnt   <= '0;
          force_pend <= 1'b0;
        end
        ST_SETTLE: begin
          if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
          if (!gs_same)               stab_cnt <= '0;
          else if (stab_cnt != 4'hF)  stab_cnt <= stab_cnt + 4'd1;
          force_pend <= wait_hit && !stab_hit;
          if (!cyc) owner <= 4'd0;
        end
        ST_DECIDE: begin
          owner     <= dec_owner;
          conflict  <= dec_conflict;
          forced    <= force_pend;
          claim_stb <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
